// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: two-flop input synchronizer, mid-bit sampling FSM,
// registered one-cycle data-ready and framing-error pulses.
module uart_rx_core #(
  parameter int unsigned CLKS_PER_BIT = 10417
) (
  input  logic       clk_i,
  input  logic       reset_i,
  input  logic       rx,
  output logic [7:0] data_o,
  output logic       rx_data_rdy_o,
  output logic       frame_err_o,
  output logic       busy_o
);

  localparam int unsigned CNT_W = $clog2(CLKS_PER_BIT);
  localparam logic [CNT_W-1:0] HALF_LAST = CNT_W'(CLKS_PER_BIT / 2 - 1);
  localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_IDLE
  } state_e;

  state_e           state_q;
  logic [CNT_W-1:0] cnt_q;
  logic [2:0]       bit_idx_q;
  logic [7:0]       shift_q;
  logic [7:0]       data_q;
  logic             rdy_q;
  logic             err_q;
  logic             rx_meta_q;
  logic             rx_s_q;

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rx_meta_q <= 1'b1;
      rx_s_q    <= 1'b1;
    end else begin
      rx_meta_q <= rx;
      rx_s_q    <= rx_meta_q;
    end
  end

  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_q   <= IDLE;
      cnt_q     <= '0;
      bit_idx_q <= '0;
      shift_q   <= '0;
      data_q    <= '0;
      rdy_q     <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      rdy_q <= 1'b0;
      err_q <= 1'b0;
      case (state_q)
        IDLE: begin
          cnt_q <= '0;
          if (!rx_s_q) state_q <= START;
        end
        // Re-check the line at mid start bit; a high level means it was a glitch.
        START: begin
          if (cnt_q == HALF_LAST) begin
            cnt_q     <= '0;
            bit_idx_q <= '0;
            state_q   <= rx_s_q ? IDLE : DATA;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        DATA: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q             <= '0;
            shift_q[bit_idx_q] <= rx_s_q;
            if (bit_idx_q == 3'd7) state_q <= STOP;
            else bit_idx_q <= bit_idx_q + 3'd1;
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        STOP: begin
          if (cnt_q == BIT_LAST) begin
            cnt_q <= '0;
            if (rx_s_q) begin
              data_q  <= shift_q;
              rdy_q   <= 1'b1;
              state_q <= IDLE;
            end else begin
              err_q   <= 1'b1;
              state_q <= WAIT_IDLE;
            end
          end else begin
            cnt_q <= cnt_q + CNT_W'(1);
          end
        end
        // A held-low line (break) parks here so it reports only one error.
        WAIT_IDLE: begin
          cnt_q <= '0;
          if (rx_s_q) state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
          cnt_q   <= '0;
        end
      endcase
    end
  end

  assign data_o        = data_q;
  assign rx_data_rdy_o = rdy_q;
  assign frame_err_o   = err_q;
  assign busy_o        = (state_q != IDLE);

endmodule

// File: tb/tb_uart_rx_core.sv
// Directed bench for uart_rx_core at 16 clocks per bit: framing, glitch,
// break, back-to-back, mid-frame reset and +/-2% baud offset frames.
`timescale 1ns/1ps
module tb_uart_rx_core;

  localparam int CPB = 16;

  logic       clk_i = 1'b0;
  logic       reset_i;
  logic       rx;
  logic [7:0] data_o;
  logic       rx_data_rdy_o;
  logic       frame_err_o;
  logic       busy_o;

  int tests = 0;
  int fails = 0;

  int cyc = 0;
  int rdy_cnt = 0;
  int err_cnt = 0;
  int both_cnt = 0;
  int busy_cnt = 0;
  int rdy_cyc = 0;
  int prev_cyc = 0;
  logic [7:0] rdy_data = '0;
  logic [7:0] prev_data = '0;
  int start_cyc = 0;

  uart_rx_core #(.CLKS_PER_BIT(CPB)) dut (
    .clk_i         (clk_i),
    .reset_i       (reset_i),
    .rx            (rx),
    .data_o        (data_o),
    .rx_data_rdy_o (rx_data_rdy_o),
    .frame_err_o   (frame_err_o),
    .busy_o        (busy_o)
  );

  always #5 clk_i = ~clk_i;

  always @(posedge clk_i) cyc <= cyc + 1;

  always @(negedge clk_i) begin
    if (rx_data_rdy_o) begin
      rdy_cnt   <= rdy_cnt + 1;
      prev_cyc  <= rdy_cyc;
      prev_data <= rdy_data;
      rdy_cyc   <= cyc;
      rdy_data  <= data_o;
    end
    if (frame_err_o) err_cnt <= err_cnt + 1;
    if (frame_err_o && rx_data_rdy_o) both_cnt <= both_cnt + 1;
    if (busy_o) busy_cnt <= busy_cnt + 1;
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk_i);
    #1;
  endtask

  task automatic send_byte(input logic [7:0] b, input logic stop_bit);
    rx = 1'b0;
    start_cyc = cyc;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = stop_bit;
    tick(CPB);
  endtask

  task automatic test_reset;
    reset_i = 1'b1;
    rx = 1'b1;
    #2;
    tests++;
    if ({data_o, rx_data_rdy_o, frame_err_o, busy_o} !== 11'h000) begin
      fails++;
      $display("FAIL reset_outputs: got %h required 000", {data_o, rx_data_rdy_o, frame_err_o, busy_o});
    end
    tick(3);
    reset_i = 1'b0;
    tick(4);
    tests++;
    if (busy_o !== 1'b0 || data_o !== 8'h00) begin
      fails++;
      $display("FAIL post_reset_idle: busy=%b data=%h required busy=0 data=00", busy_o, data_o);
    end
  endtask

  task automatic test_frame_a5;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_byte(8'hA5, 1'b1);
    tick(CPB);
    tests++;
    if (data_o !== 8'hA5) begin
      fails++; $display("FAIL a5_data: got %h required a5", data_o);
    end
    tests++;
    if (rdy_cnt - r0 !== 1) begin
      fails++; $display("FAIL a5_rdy_count: got %0d required 1", rdy_cnt - r0);
    end
    tests++;
    if (rdy_cyc - start_cyc !== 155) begin
      fails++; $display("FAIL a5_latency: got %0d required 155", rdy_cyc - start_cyc);
    end
    tests++;
    if (err_cnt !== e0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL a5_no_err_idle: errs=%0d busy=%b required errs=%0d busy=0", err_cnt - e0, busy_o, 0);
    end
  endtask

  task automatic test_glitch;
    int r0, e0, b0;
    r0 = rdy_cnt; e0 = err_cnt; b0 = busy_cnt;
    rx = 1'b0;
    tick(5);
    rx = 1'b1;
    tick(30);
    tests++;
    if (busy_cnt - b0 !== 8) begin
      fails++; $display("FAIL glitch_busy_cycles: got %0d required 8", busy_cnt - b0);
    end
    tests++;
    if (rdy_cnt !== r0 || err_cnt !== e0 || data_o !== 8'hA5 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL glitch_quiet: rdy=%0d err=%0d data=%h busy=%b required 0 0 a5 0",
               rdy_cnt - r0, err_cnt - e0, data_o, busy_o);
    end
  endtask

  task automatic test_frame_err;
    int r0, e0;
    r0 = rdy_cnt; e0 = err_cnt;
    send_byte(8'h3C, 1'b0);
    tick(40 * CPB);
    tests++;
    if (err_cnt - e0 !== 1) begin
      fails++; $display("FAIL break_err_count: got %0d required 1", err_cnt - e0);
    end
    tests++;
    if (rdy_cnt !== r0 || data_o !== 8'hA5) begin
      fails++; $display("FAIL break_data_kept: rdy=%0d data=%h required 0 a5", rdy_cnt - r0, data_o);
    end
    tests++;
    if (busy_o !== 1'b1) begin
      fails++; $display("FAIL break_busy_held: got %b required 1", busy_o);
    end
    rx = 1'b1;
    tick(4);
    tests++;
    if (busy_o !== 1'b0 || err_cnt - e0 !== 1) begin
      fails++; $display("FAIL break_release: busy=%b errs=%0d required 0 1", busy_o, err_cnt - e0);
    end
    tick(2 * CPB);
  endtask

  task automatic test_back_to_back;
    int r0;
    r0 = rdy_cnt;
    send_byte(8'h00, 1'b1);
    send_byte(8'hFF, 1'b1);
    tick(CPB);
    tests++;
    if (rdy_cnt - r0 !== 2) begin
      fails++; $display("FAIL b2b_count: got %0d required 2", rdy_cnt - r0);
    end
    tests++;
    if (prev_data !== 8'h00 || rdy_data !== 8'hFF || data_o !== 8'hFF) begin
      fails++; $display("FAIL b2b_data: got %h %h required 00 ff", prev_data, rdy_data);
    end
    tests++;
    if (rdy_cyc - prev_cyc !== 160) begin
      fails++; $display("FAIL b2b_spacing: got %0d required 160", rdy_cyc - prev_cyc);
    end
  endtask

  task automatic test_reset_midframe;
    int r0, e0;
    logic [7:0] b;
    b = 8'h55;
    r0 = rdy_cnt; e0 = err_cnt;
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 4; i++) begin
      rx = b[i];
      tick(CPB);
    end
    rx = b[4];
    tick(CPB / 2);
    #2;
    reset_i = 1'b1;
    #1;
    tests++;
    if ({data_o, rx_data_rdy_o, frame_err_o, busy_o} !== 11'h000) begin
      fails++;
      $display("FAIL midframe_reset_outputs: got %h required 000", {data_o, rx_data_rdy_o, frame_err_o, busy_o});
    end
    rx = 1'b1;
    tick(2);
    reset_i = 1'b0;
    tick(20 * CPB);
    tests++;
    if (rdy_cnt !== r0 || err_cnt !== e0 || data_o !== 8'h00 || busy_o !== 1'b0) begin
      fails++;
      $display("FAIL midframe_no_pulse: rdy=%0d err=%0d data=%h busy=%b required 0 0 00 0",
               rdy_cnt - r0, err_cnt - e0, data_o, busy_o);
    end
    send_byte(8'h81, 1'b1);
    tick(CPB);
    tests++;
    if (data_o !== 8'h81 || rdy_cnt - r0 !== 1 || rdy_cyc - start_cyc !== 155) begin
      fails++;
      $display("FAIL after_reset_frame: data=%h rdy=%0d lat=%0d required 81 1 155",
               data_o, rdy_cnt - r0, rdy_cyc - start_cyc);
    end
  endtask

  task automatic test_baud_offset;
    int r0, e0;
    logic [7:0] b;
    realtime bit_ns;
    e0 = err_cnt;
    for (int f = 0; f < 250; f++) begin
      b = 8'($urandom_range(0, 255));
      bit_ns = (f % 2 == 0) ? 163.2 : 156.8;
      r0 = rdy_cnt;
      rx = 1'b0;
      #(bit_ns);
      for (int i = 0; i < 8; i++) begin
        rx = b[i];
        #(bit_ns);
      end
      rx = 1'b1;
      #(3.0 * bit_ns);
      tests++;
      if (rdy_cnt - r0 !== 1 || data_o !== b) begin
        fails++;
        $display("FAIL baud_frame_%0d: data=%h rdy=%0d required %h 1", f, data_o, rdy_cnt - r0, b);
      end
    end
    tests++;
    if (err_cnt !== e0) begin
      fails++; $display("FAIL baud_frame_errs: got %0d required 0", err_cnt - e0);
    end
  endtask

  task automatic test_pulses_exclusive;
    tick(4);
    tests++;
    if (both_cnt !== 0 || busy_o !== 1'b0) begin
      fails++; $display("FAIL pulse_exclusive: both=%0d busy=%b required 0 0", both_cnt, busy_o);
    end
  endtask

  initial begin
    test_reset;
    test_frame_a5;
    test_glitch;
    test_frame_err;
    test_back_to_back;
    test_reset_midframe;
    test_baud_offset;
    test_pulses_exclusive;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
